// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter
// Brief  : Two-port (core C / debug D) arbiter in front of a single-port data
//          memory with starvation guard and exclusive debug lock.
// Rev    : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_AW   = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [3:0]        c_be,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_stall,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_locked,

    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] C_UNLOCKED   = 2'd0;
    localparam logic [1:0] C_LOCK_PEND  = 2'd1;
    localparam logic [1:0] C_LOCKED     = 2'd2;

    localparam logic [3:0] C_WAIT_LIMIT = 4'(MAX_WAIT);
    localparam logic [3:0] C_WAIT_SAT   = 4'hF;
    localparam logic [3:0] C_READ_BE    = 4'hF;

    logic [1:0]        r_lock_state;
    logic [1:0]        w_lock_next;
    logic [3:0]        r_wait_cnt;
    logic              r_rd_pend;
    logic              r_rd_owner_d;

    logic              w_c_gnt;
    logic              w_d_gnt;
    logic              w_access;
    logic              w_read;
    logic              w_c_outstanding;
    logic              w_sel_we;
    logic [3:0]        w_sel_be;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_unused;

    // While the lock is pending or held the core is shut out; the debug port
    // keeps the memory busy rather than leaving the cycle idle.
    always_comb begin
        w_c_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (!rst) begin
            if (r_lock_state != C_UNLOCKED) begin
                w_d_gnt = d_req;
            end else if (c_req && d_req) begin
                if (r_wait_cnt >= C_WAIT_LIMIT) begin
                    w_d_gnt = 1'b1;
                end else begin
                    w_c_gnt = 1'b1;
                end
            end else begin
                w_c_gnt = c_req;
                w_d_gnt = d_req;
            end
        end
    end

    assign w_access    = w_c_gnt | w_d_gnt;
    assign w_sel_we    = w_d_gnt ? d_we    : c_we;
    assign w_sel_be    = w_d_gnt ? d_be    : c_be;
    assign w_sel_addr  = w_d_gnt ? d_addr  : c_addr;
    assign w_sel_wdata = w_d_gnt ? d_wdata : c_wdata;
    assign w_read      = w_access & ~w_sel_we;

    assign w_c_outstanding = r_rd_pend & ~r_rd_owner_d;

    always_comb begin
        w_lock_next = r_lock_state;
        case (r_lock_state)
            C_UNLOCKED: begin
                if (d_lock) begin
                    w_lock_next = C_LOCK_PEND;
                end
            end
            C_LOCK_PEND: begin
                if (!d_lock) begin
                    w_lock_next = C_UNLOCKED;
                end else if (!w_c_gnt && !w_c_outstanding) begin
                    w_lock_next = C_LOCKED;
                end
            end
            C_LOCKED: begin
                if (!d_lock) begin
                    w_lock_next = C_UNLOCKED;
                end
            end
            default: begin
                w_lock_next = C_UNLOCKED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_state <= C_UNLOCKED;
        end else begin
            r_lock_state <= w_lock_next;
        end
    end

    // Counts consecutive cycles port D was refused; any grant or idle cycle clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 4'd0;
        end else if (d_req && !w_d_gnt) begin
            if (r_wait_cnt != C_WAIT_SAT) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end else begin
            r_wait_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend    <= 1'b0;
            r_rd_owner_d <= 1'b0;
        end else begin
            r_rd_pend <= w_read;
            if (w_read) begin
                r_rd_owner_d <= w_d_gnt;
            end
        end
    end

    assign c_gnt    = w_c_gnt;
    assign d_gnt    = w_d_gnt;
    assign c_stall  = ~rst & c_req & ~w_c_gnt;
    assign d_locked = ~rst & (r_lock_state == C_LOCKED);

    assign mem_en    = w_access;
    assign mem_we    = w_access & w_sel_we;
    assign mem_be    = !w_access ? 4'h0 : (w_sel_we ? w_sel_be : C_READ_BE);
    assign mem_addr  = w_access ? w_sel_addr[MEM_AW+1:2] : '0;
    assign mem_wdata = w_access ? w_sel_wdata : '0;

    // Gating with rst drops a response whose read was granted just before reset.
    assign c_rvalid = ~rst & r_rd_pend & ~r_rd_owner_d;
    assign d_rvalid = ~rst & r_rd_pend &  r_rd_owner_d;
    assign c_rdata  = c_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

    assign w_unused = ^{w_sel_addr[ADDR_W-1:MEM_AW+2], w_sel_addr[1:0]};

endmodule
`default_nettype wire
